// File: rtl/mvm_pkg.sv
// Shared types and helpers for the fully-connected layer pipeline.
package mvm_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  // Ceiling log2, never below 1 so that degenerate sizes still get a 1-bit counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Clamp a sign-extended accumulator value into the signed range of a t-bit word.
  function automatic logic signed [63:0] sat_t(input logic signed [63:0] v, input int t);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (t - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (t - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mvm_layer_pipe_if.sv
// Valid/ready stream bundle.
// A beat transfers on a rising clk edge where valid && ready are both high.
// The master holds data stable while valid && !ready; ready never depends
// combinationally on valid, and valid never depends combinationally on ready.
interface mvm_layer_pipe_if #(
  parameter int T = 8
);
  logic         valid;
  logic         ready;
  logic [T-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mvm_mac_unit.sv
// Multiply-accumulate datapath for one output neuron at a time:
// x register -> product register -> wide accumulator -> saturate/ReLU output register.
module mvm_mac_unit import mvm_pkg::*; #(
  parameter int N    = 8,
  parameter int T    = 8,
  parameter int RELU = 1,
  parameter int SAT  = 1,
  localparam int PW  = 2 * T,
  localparam int A   = 2 * T + clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         issue,
  input  logic         first,
  input  logic         load_out,
  input  logic [T-1:0] x_rd,
  input  logic [T-1:0] w_data,
  input  logic [T-1:0] b_data,
  output logic [T-1:0] y
);

  logic                 v1, f1, v2, f2;
  logic signed [T-1:0]  x_q;
  logic signed [PW-1:0] prod;
  logic signed [A-1:0]  acc;
  logic signed [T-1:0]  sat_v;
  logic [T-1:0]         y_nxt;

  // Pipeline: x is registered alongside the ROM read, then multiplied, then accumulated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      f1   <= 1'b0;
      x_q  <= '0;
      v2   <= 1'b0;
      f2   <= 1'b0;
      prod <= '0;
      acc  <= '0;
      y    <= '0;
    end else begin
      v1   <= issue;
      f1   <= issue && first;
      x_q  <= x_rd;
      v2   <= v1;
      f2   <= f1;
      prod <= PW'($signed(w_data)) * PW'(x_q);
      if (v2) acc <= (f2 ? A'($signed(b_data)) : acc) + A'(prod);
      if (load_out) y <= y_nxt;
    end
  end

  // Output stage: saturate or truncate to T bits, then optional ReLU.
  always_comb begin
    sat_v = (SAT != 0) ? T'(sat_t(64'(acc), T)) : acc[T-1:0];
    y_nxt = ((RELU != 0) && sat_v[T-1]) ? '0 : sat_v;
  end

endmodule

// File: rtl/mvm_layer_pipe.sv
// Fully-connected layer y = act(W*x + b) with a ping-pong x buffer so the
// next input vector can load while the current one is being computed.
module mvm_layer_pipe import mvm_pkg::*; #(
  parameter int M    = 8,
  parameter int N    = 8,
  parameter int T    = 8,
  parameter int RELU = 1,
  parameter int SAT  = 1,
  localparam int WA  = clog2(M * N),
  localparam int RW  = clog2(M)
) (
  input  logic            clk,
  input  logic            reset_n,
  mvm_layer_pipe_if.slave  s_in,
  mvm_layer_pipe_if.master m_out,
  output logic [WA-1:0]   w_addr,
  input  logic [T-1:0]    w_data,
  output logic [RW-1:0]   b_addr,
  input  logic [T-1:0]    b_data,
  output state_t          dbg_state
);

  localparam int CW = clog2(N);

  state_t         state, state_nxt;
  logic [CW-1:0]  col, fill_cnt;
  logic [RW-1:0]  row;
  logic [1:0]     dcnt;
  logic [T-1:0]   xmem [2][N];
  logic [1:0]     bank_full;
  logic           fill_sel, comp_sel, run;
  logic           in_fire, out_fire, last_col, last_row, issue, load_out;
  logic [T-1:0]   x_rd, y;

  // run keeps s_ready low until the first clock edge out of reset.
  assign s_in.ready  = run && !bank_full[fill_sel];
  assign in_fire     = s_in.valid && s_in.ready;
  assign m_out.valid = (state == OUT);
  assign m_out.data  = y;
  assign out_fire    = m_out.valid && m_out.ready;
  assign last_col    = (col == CW'(N - 1));
  assign last_row    = (row == RW'(M - 1));
  assign issue       = (state == MAC);
  assign load_out    = (state == DRAIN) && (dcnt == 2'd2);
  assign b_addr      = row;
  assign x_rd        = xmem[comp_sel][col];
  assign dbg_state   = state;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: one row = N MAC cycles, 3 drain cycles, then hold in OUT until accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bank_full[comp_sel]) state_nxt = MAC;
      MAC:     if (last_col) state_nxt = DRAIN;
      DRAIN:   if (dcnt == 2'd2) state_nxt = OUT;
      OUT:     if (out_fire) state_nxt = last_row ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  // Column/row/drain counters and the weight address, which simply walks row-major and wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col    <= '0;
      row    <= '0;
      dcnt   <= '0;
      w_addr <= '0;
    end else begin
      if (state == MAC) col <= last_col ? '0 : col + CW'(1);
      dcnt <= ((state == DRAIN) && (dcnt != 2'd2)) ? dcnt + 2'd1 : 2'd0;
      if (((state == MAC) && !last_col) || out_fire)
        w_addr <= (w_addr == WA'(M * N - 1)) ? '0 : w_addr + WA'(1);
      if (out_fire) row <= last_row ? '0 : row + RW'(1);
    end
  end

  // Bank bookkeeping: fill pointer hops to the other bank once it is empty; compute bank swaps after the last row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_full <= '0;
      fill_sel  <= 1'b0;
      comp_sel  <= 1'b0;
      fill_cnt  <= '0;
      run       <= 1'b0;
    end else begin
      run <= 1'b1;
      if (in_fire) begin
        fill_cnt <= (fill_cnt == CW'(N - 1)) ? '0 : fill_cnt + CW'(1);
        if (fill_cnt == CW'(N - 1)) bank_full[fill_sel] <= 1'b1;
      end
      if (out_fire && last_row) begin
        bank_full[comp_sel] <= 1'b0;
        comp_sel            <= ~comp_sel;
      end
      if (bank_full[fill_sel] && !bank_full[~fill_sel]) fill_sel <= ~fill_sel;
    end
  end

  // x storage: two banks of N elements, written in arrival order.
  always_ff @(posedge clk) begin
    if (in_fire) xmem[fill_sel][fill_cnt] <= s_in.data;
  end

  mvm_mac_unit #(.N(N), .T(T), .RELU(RELU), .SAT(SAT)) u_mac (
    .clk      (clk),
    .rst_n    (reset_n),
    .issue    (issue),
    .first    (col == '0),
    .load_out (load_out),
    .x_rd     (x_rd),
    .w_data   (w_data),
    .b_data   (b_data),
    .y        (y)
  );

endmodule

// File: tb/tb_mvm_layer_pipe.sv
// Directed bench for mvm_layer_pipe: a ReLU instance and a linear instance
// share the same input stream and handshake; each has its own weight ROM.
module tb_mvm_layer_pipe;
  import mvm_pkg::*;

  localparam int M = 8;
  localparam int N = 8;
  localparam int T = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mvm_layer_pipe_if #(.T(T)) s_if1 ();
  mvm_layer_pipe_if #(.T(T)) m_if1 ();
  mvm_layer_pipe_if #(.T(T)) s_if0 ();
  mvm_layer_pipe_if #(.T(T)) m_if0 ();

  logic [5:0] w_addr1, w_addr0;
  logic [2:0] b_addr1, b_addr0;
  logic [7:0] w_data1 = '0, w_data0 = '0, b_data1 = '0, b_data0 = '0;
  state_t     st1, st0;
  logic [7:0] w_mem1 [64];
  logic [7:0] w_mem0 [64];
  logic [7:0] b_mem [8];

  int passed = 0;
  int total  = 0;

  mvm_layer_pipe #(.M(M), .N(N), .T(T), .RELU(1), .SAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .s_in(s_if1), .m_out(m_if1),
    .w_addr(w_addr1), .w_data(w_data1), .b_addr(b_addr1), .b_data(b_data1),
    .dbg_state(st1)
  );

  mvm_layer_pipe #(.M(M), .N(N), .T(T), .RELU(0), .SAT(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .s_in(s_if0), .m_out(m_if0),
    .w_addr(w_addr0), .w_data(w_data0), .b_addr(b_addr0), .b_data(b_data0),
    .dbg_state(st0)
  );

  // Synchronous weight/bias ROMs: data one cycle after address.
  always @(posedge clk) begin
    w_data1 <= w_mem1[w_addr1];
    w_data0 <= w_mem0[w_addr0];
    b_data1 <= b_mem[b_addr1];
    b_data0 <= b_mem[b_addr0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_in(input logic v, input logic [7:0] d);
    s_if1.valid = v;
    s_if0.valid = v;
    s_if1.data  = d;
    s_if0.data  = d;
  endtask

  task automatic set_ready(input logic r);
    m_if1.ready = r;
    m_if0.ready = r;
  endtask

  // mode 0: W[r][c] = r-4 in both ROMs; mode 1: 127 for the ReLU instance, -128 for the linear one.
  task automatic load_w(input int mode);
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        w_mem1[r*N+c] = (mode == 0) ? 8'(r - 4) : 8'd127;
        w_mem0[r*N+c] = (mode == 0) ? 8'(r - 4) : 8'h80;
      end
    end
  endtask

  task automatic load_b(input bit use_bias);
    for (int r = 0; r < M; r++) b_mem[r] = use_bias ? 8'(r - 3) : 8'd0;
  endtask

  // Stream one vector; gaps counts cycles without a transfer after the first accepted element.
  task automatic push_vec(input logic [7:0] xv [8], input bit toggle, output int gaps);
    int  i;
    int  k;
    bit  started;
    logic v;
    i = 0; k = 0; started = 0; gaps = 0;
    while (i < N && k < 400) begin
      v = toggle ? !k[0] : 1'b1;
      drive_in(v, xv[i]);
      if (v && s_if1.ready) begin
        i++;
        started = 1;
      end else if (started) begin
        gaps++;
      end
      @(negedge clk);
      k++;
    end
    drive_in(1'b0, 8'd0);
    check("push_count", i, N);
  endtask

  // Collect nrows results, checking value, latency, stall stability and valid drop after each handshake.
  task automatic pull_rows(input logic [7:0] e1 [8], input logic [7:0] e0 [8],
                           input int nrows, input int stall_row, input int exp_gap);
    for (int r = 0; r < nrows; r++) begin
      int g;
      int lat;
      logic [7:0] d0;
      g = 0; lat = 0;
      while (st1 != MAC && g < 400) begin
        @(negedge clk);
        g++;
      end
      if (r == 0 && exp_gap >= 0) check("idle_gap", g, exp_gap);
      while (!m_if1.valid && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("latency_row%0d", r), lat, N + 3);
      if (r == stall_row) begin
        d0 = m_if1.data;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_valid", m_if1.valid, 1);
          check("stall_data", m_if1.data, d0);
        end
        set_ready(1'b1);
      end
      check($sformatf("y_relu_row%0d", r), m_if1.data, e1[r]);
      check($sformatf("y_lin_row%0d", r), m_if0.data, e0[r]);
      @(negedge clk);
      check("valid_drop", m_if1.valid, 0);
      if (r + 1 == stall_row) set_ready(1'b0);
    end
    if (nrows == M) begin
      check("w_addr_wrap", w_addr1, 0);
      check("b_addr_wrap", b_addr1, 0);
    end
  endtask

  initial begin
    logic [7:0] x_ones [8];
    logic [7:0] x_127 [8];
    logic [7:0] x_ramp [8];
    logic [7:0] e1_t1 [8];
    logic [7:0] e0_t1 [8];
    logic [7:0] e1_sat [8];
    logic [7:0] e0_sat [8];
    logic [7:0] e1_ramp [8];
    logic [7:0] e0_ramp [8];
    logic [7:0] e1_bias [8];
    logic [7:0] e0_bias [8];
    int gaps;

    x_ones  = '{default: 8'd1};
    x_127   = '{default: 8'd127};
    x_ramp  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    e1_t1   = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd8, 8'd16, 8'd24};
    e0_t1   = '{8'he0, 8'he8, 8'hf0, 8'hf8, 8'd0, 8'd8, 8'd16, 8'd24};
    e1_sat  = '{default: 8'h7f};
    e0_sat  = '{default: 8'h80};
    e1_ramp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h24, 8'h48, 8'h6c};
    e0_ramp = '{8'h80, 8'h94, 8'hb8, 8'hdc, 8'd0, 8'h24, 8'h48, 8'h6c};
    e1_bias = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'h0a, 8'h13, 8'h1c};
    e0_bias = '{8'hdd, 8'he6, 8'hef, 8'hf8, 8'd1, 8'h0a, 8'h13, 8'h1c};

    drive_in(1'b0, 8'd0);
    set_ready(1'b1);
    load_w(0);
    load_b(1'b0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values while reset_n is held low.
    check("rst_s_ready", s_if1.ready, 0);
    check("rst_m_valid", m_if1.valid, 0);
    check("rst_data_out", m_if1.data, 0);
    check("rst_w_addr", w_addr1, 0);
    check("rst_b_addr", b_addr1, 0);
    check("rst_state", st1, IDLE);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", s_if1.ready, 1);
    check("idle_after_reset", st1, IDLE);

    // Basic layer: x all 1, W row r = r-4, b = 0.
    fork
      push_vec(x_ones, 1'b0, gaps);
      pull_rows(e1_t1, e0_t1, 8, -1, -1);
    join

    // Saturation in both directions.
    load_w(1);
    fork
      push_vec(x_127, 1'b0, gaps);
      pull_rows(e1_sat, e0_sat, 8, -1, -1);
    join
    load_w(0);

    // Backpressure for 5 cycles on row 3.
    fork
      push_vec(x_ones, 1'b0, gaps);
      pull_rows(e1_t1, e0_t1, 8, 3, -1);
    join

    // Ping-pong: second vector loads while the first computes, one IDLE cycle between them.
    fork
      begin
        push_vec(x_ones, 1'b0, gaps);
        push_vec(x_ramp, 1'b0, gaps);
        check("pingpong_gaps", gaps, 0);
      end
      begin
        pull_rows(e1_t1, e0_t1, 8, -1, -1);
        pull_rows(e1_ramp, e0_ramp, 8, -1, 1);
      end
    join

    // s_valid toggling during load.
    fork
      push_vec(x_ones, 1'b1, gaps);
      pull_rows(e1_t1, e0_t1, 8, -1, -1);
    join

    // Reset mid-MAC on row 4, then a fresh vector with non-zero bias.
    fork
      push_vec(x_ones, 1'b0, gaps);
      pull_rows(e1_t1, e0_t1, 4, -1, -1);
    join
    repeat (2) @(negedge clk);
    check("pre_reset_mac", st1, MAC);
    #2 reset_n = 1'b0;
    #1;
    check("async_m_valid", m_if1.valid, 0);
    check("async_data_out_lin", m_if0.data, 0);
    check("async_s_ready", s_if1.ready, 0);
    check("async_w_addr", w_addr1, 0);
    check("async_b_addr", b_addr0, 0);
    check("async_state", st1, IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    load_b(1'b1);
    fork
      push_vec(x_ones, 1'b0, gaps);
      pull_rows(e1_bias, e0_bias, 8, -1, -1);
    join

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1, "time limit");
  end

endmodule
